// File: rtl/dec_stage_pkg.sv
// ============================================================================
//  Module      : dec_stage_pkg
//  Description : Shared ISA constants, opcode map and immediate-extension
//                mode decode for the instruction-decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_stage_pkg;

    // Instruction field positions
    localparam int unsigned c_OP_LSB  = 26;
    localparam int unsigned c_RS_LSB  = 21;
    localparam int unsigned c_RD_LSB  = 16;
    localparam int unsigned c_RT_LSB  = 11;
    localparam int unsigned c_OP_W    = 6;
    localparam int unsigned c_FUNC_W  = 6;
    localparam int unsigned c_REG_W   = 5;
    localparam int unsigned c_IMM_W   = 16;
    localparam int unsigned c_DATA_W  = 32;

    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_RTYPE = 6'b100000;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_HI16 = 2'd2,
        EXT_BR   = 2'd3
    } ext_mode_t;

    // Anything not explicitly zero/high/branch falls back to sign extension
    function automatic ext_mode_t ext_mode_of(input logic [5:0] opcode);
        ext_mode_t mode;
        case (opcode)
            OP_ANDI, OP_ORI:       mode = EXT_ZERO;
            OP_LUI:                mode = EXT_HI16;
            OP_B, OP_BEQ, OP_BNE:  mode = EXT_BR;
            default:               mode = EXT_SIGN;
        endcase
        return mode;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_stage_regfile_32x32.sv
// ============================================================================
//  Module      : regfile_32x32
//  Description : 32x32 register file, two async read ports, one sync write
//                port, R0 hardwired to zero. `DEC_BYPASS_EN enables
//                write-to-read forwarding on both read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_32x32
    import dec_stage_pkg::*;
(
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [c_REG_W-1:0]  i_wr_addr,
    input  logic [c_DATA_W-1:0] i_wr_data,
    input  logic [c_REG_W-1:0]  i_rd_addr_a,
    input  logic [c_REG_W-1:0]  i_rd_addr_b,
    output logic [c_DATA_W-1:0] o_rd_data_a,
    output logic [c_DATA_W-1:0] o_rd_data_b
);

    logic [c_DATA_W-1:0] r_mem [32];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef DEC_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;

    assign w_fwd_a = i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr_a);
    assign w_fwd_b = i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr_b);

    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : (w_fwd_a ? i_wr_data : r_mem[i_rd_addr_a]);
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : (w_fwd_b ? i_wr_data : r_mem[i_rd_addr_b]);
`else
    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_mem[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_mem[i_rd_addr_b];
`endif

endmodule

`default_nettype wire

// File: rtl/dec_stage.sv
// ============================================================================
//  Module      : dec_stage
//  Description : Instruction-decode stage: IR, register-file read/write-back,
//                immediate extension and registered operands for execute.
//                Optional macro `DEC_BYPASS_EN forwards same-edge writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_stage
    import dec_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        IR_LdEn,
    input  logic        RF_WrEn,
    input  logic        RF_B_sel,
    input  logic        RF_WrData_sel,
    input  logic [31:0] ALU_out,
    input  logic [31:0] MEM_out,
    output logic [5:0]  Opcode,
    output logic [5:0]  Func,
    output logic [31:0] RF_A,
    output logic [31:0] RF_B,
    output logic [31:0] Immed
);

    logic [31:0]        r_ir;
    logic [31:0]        r_rf_a;
    logic [31:0]        r_rf_b;
    logic [31:0]        r_immed;

    logic [c_REG_W-1:0] w_addr_a;
    logic [c_REG_W-1:0] w_addr_b;
    logic [c_REG_W-1:0] w_wr_addr;
    logic [31:0]        w_wr_data;
    logic [31:0]        w_rd_a;
    logic [31:0]        w_rd_b;
    logic [c_IMM_W-1:0] w_imm16;
    logic [31:0]        w_immed;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_ir <= '0;
        end else if (IR_LdEn) begin
            r_ir <= Instr;
        end
    end

    assign Opcode    = r_ir[c_OP_LSB +: c_OP_W];
    assign Func      = r_ir[0 +: c_FUNC_W];
    assign w_imm16   = r_ir[0 +: c_IMM_W];

    assign w_addr_a  = r_ir[c_RS_LSB +: c_REG_W];
    assign w_addr_b  = RF_B_sel ? r_ir[c_RD_LSB +: c_REG_W] : r_ir[c_RT_LSB +: c_REG_W];
    // Write-back targets the rd field of whatever IR holds before this edge
    assign w_wr_addr = r_ir[c_RD_LSB +: c_REG_W];
    assign w_wr_data = RF_WrData_sel ? MEM_out : ALU_out;

    regfile_32x32 u_regfile (
        .clk         (Clk),
        .i_rst_n     (Reset),
        .i_wr_en     (RF_WrEn),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   (w_wr_data),
        .i_rd_addr_a (w_addr_a),
        .i_rd_addr_b (w_addr_b),
        .o_rd_data_a (w_rd_a),
        .o_rd_data_b (w_rd_b)
    );

    always_comb begin
        w_immed = {{16{w_imm16[15]}}, w_imm16};
        case (ext_mode_of(Opcode))
            EXT_ZERO: w_immed = {16'h0000, w_imm16};
            EXT_HI16: w_immed = {w_imm16, 16'h0000};
            EXT_BR:   w_immed = {{14{w_imm16[15]}}, w_imm16, 2'b00};
            default:  w_immed = {{16{w_imm16[15]}}, w_imm16};
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rf_a  <= '0;
            r_rf_b  <= '0;
            r_immed <= '0;
        end else begin
            r_rf_a  <= w_rd_a;
            r_rf_b  <= w_rd_b;
            r_immed <= w_immed;
        end
    end

    assign RF_A  = r_rf_a;
    assign RF_B  = r_rf_b;
    assign Immed = r_immed;

endmodule

`default_nettype wire
